// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory access arbiter
//
// Contents:
//   arb_state_e     FSM encoding (IDLE / ACCESS / RESP)
//   PORT_IF/PORT_LS requester indices (instruction fetch / load-store)
//   is_misaligned   word access whose byte address is not word aligned
// No ports (package).

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    function automatic logic is_misaligned(input logic is_byte, input logic [1:0] addr_lsb);
        return !is_byte && (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational winner select between the two requesters
//
// Build option: MEM_ARB_RR_EN selects round-robin on ties; otherwise the
// load/store port (1) always beats instruction fetch (0).
// Ports:
//   req_i     in  2  eligible requests
//   rr_ptr_i  in  1  last granted port (MEM_ARB_RR_EN builds only)
//   any_o     out 1  at least one eligible request
//   winner_o  out 1  selected port index

module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
`ifdef MEM_ARB_RR_EN
    input  logic       rr_ptr_i,
`endif
    output logic       any_o,
    output logic       winner_o
);

    always_comb begin
        any_o = |req_i;
`ifdef MEM_ARB_RR_EN
        // rr_ptr_i is the port granted last, so the other one wins a tie.
        if (&req_i) begin
            winner_o = ~rr_ptr_i;
        end else begin
            winner_o = req_i[PORT_LS] ? PORT_LS : PORT_IF;
        end
`else
        winner_o = req_i[PORT_LS] ? PORT_LS : PORT_IF;
`endif
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares one memory between instruction fetch and load/store
//
// Build option: MEM_ARB_RR_EN (round-robin tie break, see mem_arb_grant).
// Ports:
//   clock, reset                    clock and synchronous active-high reset
//   req_valid/req_write/req_byte    per-port request, store flag, byte flag (2 bits)
//   req_addr0/1, req_wdata0/1       per-port byte address and store data
//   ack                             one-cycle completion pulse per port
//   resp_err                        misaligned word access, valid with ack
//   resp_rdata                      load data, valid with ack, held otherwise
//   mem_read/mem_write/mem_byte     memory strobes and byte-operation select
//   mem_address/mem_wdata           memory address and store data
//   mem_rdata                       memory read data

module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [1:0]        req_byte,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        ack,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned      CNT_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              winner_q, winner_d;
    logic              err_q, err_d;
    logic [1:0]        ack_q, ack_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef MEM_ARB_RR_EN
    logic              rr_ptr_q, rr_ptr_d;
`endif

    logic              grant_any;
    logic              grant_winner;
    logic [1:0]        req_elig;
    logic              sel_write;
    logic              sel_byte;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A port is still allowed to hold req_valid during its own ack cycle;
    // masking it there keeps one completed request from being granted twice.
    assign req_elig  = req_valid & ~ack_q;

    assign sel_write = grant_winner ? req_write[1] : req_write[0];
    assign sel_byte  = grant_winner ? req_byte[1]  : req_byte[0];
    assign sel_addr  = grant_winner ? req_addr1    : req_addr0;
    assign sel_wdata = grant_winner ? req_wdata1   : req_wdata0;

    mem_arb_grant u_grant (
        .req_i    (req_elig),
`ifdef MEM_ARB_RR_EN
        .rr_ptr_i (rr_ptr_q),
`endif
        .any_o    (grant_any),
        .winner_o (grant_winner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        winner_d   = winner_q;
        err_d      = err_q;
        ack_d      = 2'b00;
        resp_err_d = 1'b0;
        rdata_d    = rdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef MEM_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    winner_d = grant_winner;
`ifdef MEM_ARB_RR_EN
                    rr_ptr_d = grant_winner;
`endif
                    if (is_misaligned(sel_byte, sel_addr[1:0])) begin
                        // Rejected without touching the memory.
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        rd_d    = ~sel_write;
                        wr_d    = sel_write;
                        byte_d  = sel_byte;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    if (rd_q) begin
                        rdata_d = mem_rdata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    byte_d  = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                ack_d[winner_q] = 1'b1;
                resp_err_d      = err_q;
                state_d         = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            winner_q   <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= 2'b00;
            resp_err_q <= 1'b0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            byte_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            winner_q   <= winner_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            resp_err_q <= resp_err_d;
            rdata_q    <= rdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef MEM_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = rdata_q;
    assign mem_read    = rd_q;
    assign mem_write   = wr_q;
    assign mem_byte    = byte_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - randomized self-checking bench for mem_access_arbiter

module tb_mem_access_arbiter;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 32;
    localparam int HOLD_CYC = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        req_valid, req_write, req_byte;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [DATA_W-1:0] req_wdata0, req_wdata1;
    logic [1:0]        ack;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_read, mem_write, mem_byte;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    always #5 clock = ~clock;

    mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .ack(ack), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_lane(input logic [31:0] w, input logic [1:0] lane);
        return (w >> (8 * lane)) & 32'hFF;
    endfunction

    // Environment memory (what the DUT talks to) and the bench's own shadow copy.
    logic [31:0] env_mem [0:15];
    logic [31:0] ref_mem [0:15];

    assign mem_rdata = !mem_read ? 32'hBAD0_BAD0 :
                       mem_byte  ? byte_lane(env_mem[mem_address[5:2]], mem_address[1:0]) :
                                   env_mem[mem_address[5:2]];

    always @(posedge clock) begin
        if (mem_write) begin
            if (mem_byte) env_mem[mem_address[5:2]][mem_address[1:0]*8 +: 8] <= mem_wdata[7:0];
            else          env_mem[mem_address[5:2]] <= mem_wdata;
        end
    end

    // Reference state: port favoured on a tie, last delivered load data.
    int          favoured = 1;
    logic [31:0] last_rdata = '0;

    task automatic do_round(input logic [1:0] v, input logic [1:0] w, input logic [1:0] b,
                            input logic [17:0] a0, input logic [17:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
        int order[2];
        int n, idx, cyc, prev_cyc, strobes, p, lat, gap;
        logic is_err;
        logic [17:0] pa[2];
        logic [31:0] pd[2];
        logic [3:0]  wi;
        logic [1:0]  lane;
        pa[0] = a0; pa[1] = a1; pd[0] = d0; pd[1] = d1;
        if (v == 2'b11) begin
            order[0] = favoured; order[1] = 1 - favoured; n = 2;
        end else begin
            order[0] = v[1] ? 1 : 0; order[1] = 0; n = 1;
        end
`ifdef MEM_ARB_RR_EN
        favoured = 1 - order[n-1];
`endif
        req_write = w; req_byte = b;
        req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
        req_valid = v;
        idx = 0; cyc = 0; prev_cyc = 0; strobes = 0;
        while (idx < n) begin
            @(negedge clock);
            cyc++;
            p = order[idx];
            is_err = !b[p] && (pa[p][1:0] != 2'b00);
            lat = is_err ? 1 : HOLD_CYC + 1;
            if (mem_read || mem_write) begin
                strobes++;
                check_eq("mem_address", mem_address, pa[p]);
                check_eq("mem_write", mem_write, w[p]);
                check_eq("mem_read", mem_read, !w[p]);
                check_eq("mem_byte", mem_byte, b[p]);
                if (w[p]) check_eq("mem_wdata", mem_wdata, pd[p]);
            end
            if (ack != 2'b00) begin
                check_eq("ack_port", ack, 2'b01 << p);
                check_eq("ack_cycle", cyc, prev_cyc + 1 + lat);
                check_eq("strobe_cycles", strobes, is_err ? 0 : HOLD_CYC);
                check_eq("resp_err", resp_err, is_err);
                if (!is_err) begin
                    wi = pa[p][5:2]; lane = pa[p][1:0];
                    if (w[p]) begin
                        if (b[p]) ref_mem[wi][lane*8 +: 8] = pd[p][7:0];
                        else      ref_mem[wi] = pd[p];
                    end else begin
                        last_rdata = b[p] ? byte_lane(ref_mem[wi], lane) : ref_mem[wi];
                    end
                end
                check_eq("resp_rdata", resp_rdata, last_rdata);
                req_valid[p] = 1'b0;
                prev_cyc = cyc; strobes = 0; idx++;
            end else if (cyc > 40) begin
                check_eq("ack_timeout", ack, 2'b01 << p);
                req_valid = 2'b00;
                idx = n;
            end
        end
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            check_eq("idle_ack", ack, 2'b00);
            check_eq("idle_strobe", {mem_read, mem_write}, 2'b00);
        end
    endtask

    function automatic logic [17:0] rand_addr(input logic is_byte);
        logic [17:0] a;
        a = {12'h0, 4'($urandom), 2'($urandom)};
        if (!is_byte && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        logic [1:0] v, w, b;
        reset = 1'b1;
        req_valid = '0; req_write = '0; req_byte = '0;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        for (int i = 0; i < 16; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[2] = 32'hDEADBEEF;
        ref_mem[2] = 32'hDEADBEEF;
        repeat (3) @(negedge clock);
        check_eq("rst_ack", ack, 2'b00);
        check_eq("rst_resp_err", resp_err, 1'b0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_mem_byte", mem_byte, 1'b0);
        check_eq("rst_mem_address", mem_address, 18'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        do_round(2'b01, 2'b00, 2'b00, 18'h00008, 18'h0, 32'h0, 32'h0);
        do_round(2'b11, 2'b10, 2'b00, 18'h00010, 18'h00020, 32'h0, 32'h1234_5678);
        do_round(2'b10, 2'b10, 2'b00, 18'h0, 18'h00006, 32'h0, 32'hCAFE_F00D);
        do_round(2'b10, 2'b10, 2'b10, 18'h0, 18'h00003, 32'h0, 32'h0000_00AB);
        do_round(2'b01, 2'b00, 2'b01, 18'h00003, 18'h0, 32'h0, 32'h0);
        for (int r = 0; r < 4; r++) begin
            do_round(2'b11, 2'($urandom), 2'b11, rand_addr(1'b1), rand_addr(1'b1), $urandom, $urandom);
        end

        for (int r = 0; r < 60; r++) begin
            v = 2'($urandom_range(1, 3));
            w = 2'($urandom);
            b = 2'($urandom);
            do_round(v, w, b, rand_addr(b[0]), rand_addr(b[1]), $urandom, $urandom);
        end

        // Reset in the middle of an access.
        req_write = 2'b00; req_byte = 2'b00; req_addr0 = 18'h00004; req_valid = 2'b01;
        @(negedge clock);
        @(negedge clock);
        check_eq("pre_rst_read", mem_read, 1'b1);
        reset = 1'b1;
        req_valid = 2'b00;
        @(negedge clock);
        check_eq("midrst_read", mem_read, 1'b0);
        check_eq("midrst_write", mem_write, 1'b0);
        check_eq("midrst_ack", ack, 2'b00);
        check_eq("midrst_rdata", resp_rdata, 32'h0);
        reset = 1'b0;
        favoured = 1;
        last_rdata = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_eq("post_rst_ack", ack, 2'b00);
        end
        do_round(2'b11, 2'b00, 2'b00, 18'h00008, 18'h0000C, 32'h0, 32'h0);
        do_round(2'b11, 2'b00, 2'b00, 18'h00010, 18'h00014, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
